dmem_multicycle: RTL and testbench
==================================

Name: dmem_multicycle

Overview:
Parametrised multi-cycle data memory for the pipelined CPU's MEM stage. It replaces the single-cycle data memory and adds:
- a request/acknowledge handshake
- a configurable access latency
- byte-enabled writes
- a stall output for the hazard logic
- error reporting for misaligned or out-of-range accesses

The CPU holds each request until it is acknowledged, so the pipeline tolerates slow memory.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8.
DEPTH, 1024, number of words; power of 2.
ADDR_W, 32, byte address width.
LATENCY, 4, cycles from the request cycle to the ack cycle; must be >= 1.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
req_i  input  1  access request; held high by CPU until ack_o
we_i  input  1  1 = write, 0 = read; sampled with req_i
addr_i  input  ADDR_W  byte address; sampled with req_i
data_i  input  DATA_W  write data; sampled with req_i
be_i  input  DATA_W/8  byte enables for writes; bit k covers data bits [8k+7:8k]
ready_o  output  1  1 when a request can be accepted (state IDLE)
ack_o  output  1  one-cycle completion pulse
data_o  output  DATA_W  registered result word, valid when ack_o=1
err_o  output  1  error flag, valid when ack_o=1
stall_o  output  1  pipeline stall to hazard unit

Behaviour:
- One clock domain; reset is synchronous and active-high on rst_i.
- Reset values: state IDLE, ready_o=1, ack_o=0, data_o=0, err_o=0, stall_o=0. Reset also clears the latched request and the counter. Memory array contents are NOT cleared by reset.
- Address decode:
  - OFF = log2(DATA_W/8) low bits must be zero, else misaligned.
  - Word index = addr_i[OFF +: log2(DEPTH)].
  - Any nonzero bit above the index field is out-of-range.
  - Error = misaligned OR out-of-range; computed on the latched address.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: ready_o=1. If req_i=1 at the edge, latch we/addr/data/be and go to:
    - BUSY with counter = LATENCY-2, if LATENCY >= 2;
    - RESP directly, if LATENCY = 1.
  - BUSY: ready_o=0. If counter = 0 go to RESP, else decrement.
  - RESP: ready_o=0, ack_o=1 for exactly this cycle. req_i is ignored. Always return to IDLE on the next edge.
- Latency: request first high in cycle T (state IDLE) -> ack_o=1 in cycle T+LATENCY. The next request can be accepted no earlier than cycle T+LATENCY+1. Throughput is one access per LATENCY+1 cycles.
- Array access happens on the edge that enters RESP:
  - Write with no error: update only bytes whose be_i bit is 1. data_o = post-write word.
  - Read with no error: data_o = stored word.
  - Error: no array update, data_o=0, err_o=1.
  - be_i all zero on a write: no change; ack still issued, err_o=0.
- data_o and err_o are registered and hold their value until the next RESP entry or reset.
- stall_o = req_i AND NOT ack_o (combinational). It is high from the request cycle through the cycle before ack and low in the ack cycle, so the MEM stage advances on the ack edge.
- Reset mid-operation (BUSY or the edge entering RESP): no array write occurs, no ack is issued, and the FSM returns to IDLE.
- Inputs changing while in BUSY have no effect; only the latched copy is used.

Test Plan:
1. Hold rst_i=1 for 2 cycles, then release -> ready_o=1, ack_o=0, data_o=0, err_o=0, stall_o=0. Hold req_i=0 for 5 cycles -> no ack.
2. LATENCY=4: write addr 0x10, data 0xDEADBEEF, be 4'b1111 at cycle T.
   -> stall_o=1 for cycles T..T+3; ack_o=1 only in T+4 with data_o=0xDEADBEEF; ready_o=0 for T+1..T+4.
   Then read 0x10 -> data_o=0xDEADBEEF at ack, err_o=0.
3. Write 0x000000AA, be 4'b0001 to 0x10, then read 0x10 -> 0xDEADBEAA. A write with be 4'b0000 leaves 0xDEADBEAA and still acks.
4. Read addr 0x12 (misaligned) -> ack at T+4 with err_o=1, data_o=0. Write 0x55 to 0x1000 (out of range, DEPTH=1024) -> err_o=1. Word 0 is unchanged on readback.
5. Start a write of 0x12345678 to 0x20, which holds 0x0. Assert rst_i in cycle T+2 -> no ack, FSM in IDLE. A subsequent read of 0x20 returns 0x00000000.
6. LATENCY=1: back-to-back reads of 0x10 and 0x14 with req_i held -> acks in T+1 and T+3, stall_o=1 in T and T+2, and data_o matches each word.

Source files
------------

// File: rtl/dmem_multicycle.sv
// Multi-cycle data memory for the MEM stage.
// Handshaked access, fixed latency, byte enables, error reporting.
module dmem_multicycle #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic                  ready_o,
  output logic                  ack_o,
  output logic [DATA_W-1:0]     data_o,
  output logic                  err_o,
  output logic                  stall_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                latch;
  logic                enter_resp;
  logic                mem_wr;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_data;
  logic [BE_W-1:0]     acc_be;
  logic                acc_mis;
  logic                acc_oor;
  logic                acc_err;
  logic [IDX_W-1:0]    acc_idx;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   merged;

  // With a one-cycle latency the array is touched on the accept edge,
  // so the live inputs stand in for the not-yet-latched copy.
  always_comb begin
    acc_we   = we_q;
    acc_addr = addr_q;
    acc_data = wdata_q;
    acc_be   = be_q;
    if (state_q == IDLE) begin
      acc_we   = we_i;
      acc_addr = addr_i;
      acc_data = data_i;
      acc_be   = be_i;
    end
  end

  assign acc_mis = |(acc_addr & OFF_MASK);
  assign acc_oor = |(acc_addr >> (OFF + IDX_W));
  assign acc_err = acc_mis | acc_oor;
  assign acc_idx = acc_addr[OFF +: IDX_W];
  assign rd_word = mem_q[acc_idx];

  always_comb begin
    merged = rd_word;
    for (int k = 0; k < BE_W; k++) begin
      if (acc_we && acc_be[k]) begin
        merged[8*k +: 8] = acc_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch      = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          latch = 1'b1;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    data_d = data_q;
    err_d  = err_q;
    if (enter_resp) begin
      err_d  = acc_err;
      data_d = acc_err ? '0 : merged;
    end
  end

  assign mem_wr = enter_resp & acc_we & ~acc_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      if (latch) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= data_i;
        be_q    <= be_i;
      end
    end
  end

  // Array is not reset; a reset edge simply suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_wr) begin
      mem_q[acc_idx] <= merged;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign ack_o   = (state_q == RESP);
  assign data_o  = data_q;
  assign err_o   = err_q;
  assign stall_o = req_i & ~ack_o;

endmodule

// File: tb/tb_dmem_multicycle.sv
// Bench for dmem_multicycle: LATENCY=4 and LATENCY=1 instances
// checked against an array-based reference model.
module tb_dmem_multicycle;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_a, req_a, we_a;
  logic [31:0] addr_a, wd_a;
  logic [3:0]  be_a;
  logic        rdy_a, ack_a, err_a, stl_a;
  logic [31:0] rd_a;
  logic        rst_b, req_b, we_b;
  logic [31:0] addr_b, wd_b;
  logic [3:0]  be_b;
  logic        rdy_b, ack_b, err_b, stl_b;
  logic [31:0] rd_b;

  logic [31:0] mdl_a [DEPTH];
  logic [31:0] mdl_b [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  dmem_multicycle #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LATENCY(4)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we_a),
    .addr_i(addr_a), .data_i(wd_a), .be_i(be_a),
    .ready_o(rdy_a), .ack_o(ack_a), .data_o(rd_a),
    .err_o(err_a), .stall_o(stl_a)
  );

  dmem_multicycle #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LATENCY(1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we_b),
    .addr_i(addr_b), .data_i(wd_b), .be_i(be_b),
    .ready_o(rdy_b), .ack_o(ack_b), .data_o(rd_b),
    .err_o(err_b), .stall_o(stl_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit b, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] e);
    if (b) begin
      req_b = r; we_b = w; addr_b = a; wd_b = d; be_b = e;
    end else begin
      req_a = r; we_a = w; addr_a = a; wd_a = d; be_a = e;
    end
  endtask

  // One complete access; expected result from the model.
  task automatic access(input bit b, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] e, input bit keep,
                        output logic [31:0] got);
    int          lat;
    bit          exp_e;
    logic [31:0] exp_d;
    logic [31:0] cur;
    logic [31:0] r;
    int          idx;
    lat   = b ? 1 : 4;
    exp_e = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    exp_d = '0;
    idx   = int'(a / 4) % DEPTH;
    if (!exp_e) begin
      cur = b ? mdl_b[idx] : mdl_a[idx];
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (e[k]) cur[8*k +: 8] = d[8*k +: 8];
        if (b) mdl_b[idx] = cur;
        else mdl_a[idx] = cur;
      end
      exp_d = cur;
    end
    got = '0;
    @(negedge clk);
    drive(b, 1'b1, w, a, d, e);
    #1;
    chk("ready_T", b ? rdy_b : rdy_a, 1);
    chk("stall_T", b ? stl_b : stl_a, 1);
    chk("ack_T", b ? ack_b : ack_a, 0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      #1;
      if (k < lat) begin
        chk("ack_busy", b ? ack_b : ack_a, 0);
        chk("stall_busy", b ? stl_b : stl_a, 1);
        chk("ready_busy", b ? rdy_b : rdy_a, 0);
        r = $urandom;
        drive(b, 1'b1, r[0], $urandom, $urandom, r[7:4]);
      end else begin
        chk("ack", b ? ack_b : ack_a, 1);
        chk("stall_ack", b ? stl_b : stl_a, 0);
        chk("ready_ack", b ? rdy_b : rdy_a, 0);
        chk("err", b ? err_b : err_a, 32'(exp_e));
        chk("data", b ? rd_b : rd_a, exp_d);
        got = b ? rd_b : rd_a;
        if (!keep) drive(b, 1'b0, 1'b0, '0, '0, '0);
      end
    end
  endtask

  logic [31:0] got;
  logic [31:0] r;
  logic [31:0] a;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ready", rdy_a, 1);
    chk("rst_ack", ack_a, 0);
    chk("rst_data", rd_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_stall", stl_a, 0);
    chk("rst_ready1", rdy_b, 1);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("idle_ack", ack_a, 0);
      chk("idle_ack1", ack_b, 0);
    end

    access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
    chk("wr_full", got, 32'hDEADBEEF);
    access(0, 0, 32'h10, '0, 4'h0, 0, got);
    chk("rd_full", got, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    chk("data_hold", rd_a, 32'hDEADBEEF);

    access(0, 1, 32'h10, 32'h000000AA, 4'b0001, 0, got);
    access(0, 0, 32'h10, '0, 4'h0, 0, got);
    chk("rd_byte", got, 32'hDEADBEAA);
    access(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, got);
    chk("wr_be0", got, 32'hDEADBEAA);

    access(0, 1, 32'h0, 32'h0A0B0C0D, 4'hF, 0, got);
    access(0, 0, 32'h12, '0, 4'h0, 0, got);
    access(0, 1, 32'h1000, 32'h55, 4'hF, 0, got);
    access(0, 0, 32'h0, '0, 4'h0, 0, got);
    chk("word0_kept", got, 32'h0A0B0C0D);

    // Reset while BUSY.
    access(0, 1, 32'h20, 32'h0, 4'hF, 0, got);
    @(negedge clk);
    drive(0, 1, 1, 32'h20, 32'h12345678, 4'hF);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    #1;
    chk("rstb_ack", ack_a, 0);
    chk("rstb_ready", rdy_a, 1);
    chk("rstb_data", rd_a, 0);
    rst_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rstb_noack", ack_a, 0);
    end
    access(0, 0, 32'h20, '0, 4'h0, 0, got);
    chk("rstb_word", got, 32'h0);

    // Reset on the edge that would enter RESP.
    access(0, 1, 32'h24, 32'hCAFEF00D, 4'hF, 0, got);
    @(negedge clk);
    drive(0, 1, 1, 32'h24, 32'h11111111, 4'hF);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    #1;
    chk("rstr_ack", ack_a, 0);
    chk("rstr_ready", rdy_a, 1);
    rst_a = 1'b0;
    access(0, 0, 32'h24, '0, 4'h0, 0, got);
    chk("rstr_word", got, 32'hCAFEF00D);

    // LATENCY=1 back-to-back reads with req held.
    access(1, 1, 32'h10, 32'h0BADF00D, 4'hF, 0, got);
    access(1, 1, 32'h14, 32'h600DCAFE, 4'hF, 0, got);
    access(1, 0, 32'h10, '0, 4'h0, 1, got);
    chk("b2b_0", got, 32'h0BADF00D);
    access(1, 0, 32'h14, '0, 4'h0, 0, got);
    chk("b2b_1", got, 32'h600DCAFE);

    for (int w = 0; w < 16; w++) begin
      access(0, 1, 32'(w * 4), $urandom, 4'hF, 0, got);
      access(1, 1, 32'(w * 4), $urandom, 4'hF, 0, got);
    end

    for (int i = 0; i < 80; i++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        7: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        8: a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        9: a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      access(r[8], r[0], a, $urandom, r[7:4], 0, got);
      if (r[9]) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
